// File: rtl/sram_like_arbiter_if.sv
// One sram-like bus: request/address/write-data towards the slave,
// address accept, data return and read data back towards the master.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like master port between the inst-side and data-side
// masters. One transaction outstanding at a time; the grant is held from
// request issue until data return. ARB_MODE 0 = data wins ties,
// ARB_MODE 1 = round-robin against the last granted side.
module sram_like_arbiter #(
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  sram_like_arbiter_if.slave  i,
  sram_like_arbiter_if.slave  d,
  sram_like_arbiter_if.master m,
  output logic                proto_err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_I,
    ADDR_D,
    DATA_I,
    DATA_D
  } state_t;

  typedef enum logic {
    SIDE_I,
    SIDE_D
  } side_t;

  state_t r_state;
  state_t w_next;
  side_t  r_last;
  side_t  w_last_next;
  side_t  w_sel;
  side_t  w_owner;
  logic   w_owner_req;
  logic   w_mreq;
  logic   r_perr;
  logic   w_perr_set;

  // Grant selection in IDLE and owner/request of the shared port in every state
  always_comb begin
    w_sel = SIDE_I;
    if (i.req && d.req) begin
      if (ARB_MODE == 0) begin
        w_sel = SIDE_D;
      end else begin
        w_sel = (r_last == SIDE_I) ? SIDE_D : SIDE_I;
      end
    end else if (d.req) begin
      w_sel = SIDE_D;
    end

    unique case (r_state)
      ADDR_I, DATA_I: w_owner = SIDE_I;
      ADDR_D, DATA_D: w_owner = SIDE_D;
      default:        w_owner = w_sel;
    endcase

    w_owner_req = (w_owner == SIDE_D) ? d.req : i.req;
    // The data phase never issues; an owner dropping req in ADDR_x also gives m_req = 0.
    w_mreq = ((r_state == IDLE) || (r_state == ADDR_I) || (r_state == ADDR_D)) && w_owner_req;
  end

  // State, last grant and sticky protocol error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= SIDE_I;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
      r_perr  <= r_perr | w_perr_set;
    end
  end

  // Next-state, last-grant update and protocol-error detection
  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    unique case (r_state)
      IDLE: begin
        if (w_mreq) begin
          if (m.addr_ok) begin
            w_next      = (w_sel == SIDE_D) ? DATA_D : DATA_I;
            w_last_next = w_sel;
          end else begin
            w_next = (w_sel == SIDE_D) ? ADDR_D : ADDR_I;
          end
        end
      end
      ADDR_I: begin
        if (!i.req) begin
          w_next = IDLE;
        end else if (m.addr_ok) begin
          w_next      = DATA_I;
          w_last_next = SIDE_I;
        end
      end
      ADDR_D: begin
        if (!d.req) begin
          w_next = IDLE;
        end else if (m.addr_ok) begin
          w_next      = DATA_D;
          w_last_next = SIDE_D;
        end
      end
      DATA_I, DATA_D: begin
        if (m.data_ok) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase

    w_perr_set = (m.data_ok && (r_state != DATA_I) && (r_state != DATA_D))
               || (m.addr_ok && !w_mreq)
               || (((r_state == ADDR_I) || (r_state == ADDR_D)) && !w_owner_req);
  end

  // Shared-port drive from the owner and handshake routing back to the masters
  always_comb begin
    m.req     = 1'b0;
    m.wr      = 1'b0;
    m.size    = '0;
    m.addr    = '0;
    m.wdata   = '0;
    i.addr_ok = 1'b0;
    i.data_ok = 1'b0;
    d.addr_ok = 1'b0;
    d.data_ok = 1'b0;
    proto_err = 1'b0;
    i.rdata   = m.rdata;
    d.rdata   = m.rdata;
    if (!rst) begin
      m.req = w_mreq;
      if (w_owner == SIDE_D) begin
        m.wr    = d.wr;
        m.size  = d.size;
        m.addr  = d.addr;
        m.wdata = d.wdata;
      end else begin
        m.wr    = i.wr;
        m.size  = i.size;
        m.addr  = i.addr;
        m.wdata = i.wdata;
      end
      i.addr_ok = m.addr_ok && w_mreq && (w_owner == SIDE_I);
      d.addr_ok = m.addr_ok && w_mreq && (w_owner == SIDE_D);
      i.data_ok = m.data_ok && (r_state == DATA_I);
      d.data_ok = m.data_ok && (r_state == DATA_D);
      proto_err = r_perr;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Random-traffic scoreboard bench for sram_like_arbiter. Two environments
// run side by side: env0 uses ARB_MODE=0, env1 uses ARB_MODE=1. Side 0 is
// the inst master, side 1 the data master.
module tb_sram_like_arbiter;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // master-side stimulus
  logic        t_req   [2][2];
  logic        t_wr    [2][2];
  logic [1:0]  t_size  [2][2];
  logic [31:0] t_addr  [2][2];
  logic [31:0] t_wdata [2][2];
  // master-side responses
  logic        t_aok   [2][2];
  logic        t_dok   [2][2];
  logic [31:0] t_rdata [2][2];
  // shared port
  logic        t_mreq   [2];
  logic        t_mwr    [2];
  logic [1:0]  t_msize  [2];
  logic [31:0] t_maddr  [2];
  logic [31:0] t_mwdata [2];
  logic        s_aok    [2];
  logic        s_dok    [2];
  logic [31:0] s_rdata  [2];
  logic        t_perr   [2];

  for (genvar k = 0; k < 2; k++) begin : g_env
    sram_like_arbiter_if u_i ();
    sram_like_arbiter_if u_d ();
    sram_like_arbiter_if u_m ();

    assign u_i.req   = t_req[k][0];
    assign u_i.wr    = t_wr[k][0];
    assign u_i.size  = t_size[k][0];
    assign u_i.addr  = t_addr[k][0];
    assign u_i.wdata = t_wdata[k][0];
    assign u_d.req   = t_req[k][1];
    assign u_d.wr    = t_wr[k][1];
    assign u_d.size  = t_size[k][1];
    assign u_d.addr  = t_addr[k][1];
    assign u_d.wdata = t_wdata[k][1];
    assign t_aok[k][0]   = u_i.addr_ok;
    assign t_dok[k][0]   = u_i.data_ok;
    assign t_rdata[k][0] = u_i.rdata;
    assign t_aok[k][1]   = u_d.addr_ok;
    assign t_dok[k][1]   = u_d.data_ok;
    assign t_rdata[k][1] = u_d.rdata;
    assign t_mreq[k]   = u_m.req;
    assign t_mwr[k]    = u_m.wr;
    assign t_msize[k]  = u_m.size;
    assign t_maddr[k]  = u_m.addr;
    assign t_mwdata[k] = u_m.wdata;
    assign u_m.rdata   = s_rdata[k];
    assign u_m.addr_ok = s_aok[k];
    assign u_m.data_ok = s_dok[k];

    sram_like_arbiter #(.ARB_MODE(k)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .i         (u_i),
      .d         (u_d),
      .m         (u_m),
      .proto_err (t_perr[k])
    );
  end

  // expected transactions per (env, side): index k*2+s
  txn_t exp_q [4][$];

  // memory contents seen by reads
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  // ---------------- driver (masters + slave) ----------------
  logic        rst_next;
  bit          issue_en;
  bit          stray;
  bit          waiting [2][2];
  bit          s_busy  [2];
  int unsigned s_cnt   [2];
  logic [31:0] s_rd    [2];

  function automatic bit all_idle();
    bit r = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (s_busy[k]) r = 1'b0;
      for (int s = 0; s < 2; s++) if (t_req[k][s] || waiting[k][s]) r = 1'b0;
    end
    return r;
  endfunction

  task automatic cycle();
    logic aok [2][2];
    logic dok [2][2];
    txn_t tx;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 2; s++) begin
        aok[k][s] = t_aok[k][s];
        dok[k][s] = t_dok[k][s];
      end
    @(posedge clk);
    #1;
    rst = rst_next;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 2; s++) begin
        if (rst) begin
          t_req[k][s]   = 1'b0;
          waiting[k][s] = 1'b0;
        end else begin
          if (t_req[k][s] && aok[k][s]) begin
            t_req[k][s]   = 1'b0;
            waiting[k][s] = 1'b1;
          end else if (waiting[k][s] && dok[k][s]) begin
            waiting[k][s] = 1'b0;
          end
          if (!t_req[k][s] && !waiting[k][s] && issue_en && $urandom_range(0, 2) != 0) begin
            tx.wr    = ($urandom_range(0, 3) == 0);
            tx.size  = 2'($urandom_range(0, 2));
            tx.addr  = $urandom & 32'hFFFF_FFFC;
            tx.wdata = $urandom;
            exp_q[k*2+s].push_back(tx);
            t_wr[k][s]    = tx.wr;
            t_size[k][s]  = tx.size;
            t_addr[k][s]  = tx.addr;
            t_wdata[k][s] = tx.wdata;
            t_req[k][s]   = 1'b1;
          end
        end
      end
    #1;
    for (int k = 0; k < 2; k++) begin
      s_aok[k]   = 1'b0;
      s_dok[k]   = 1'b0;
      s_rdata[k] = $urandom;
      if (rst) begin
        s_busy[k] = 1'b0;
      end else if (s_busy[k]) begin
        if (s_cnt[k] == 0) begin
          s_dok[k]   = 1'b1;
          s_rdata[k] = s_rd[k];
          s_busy[k]  = 1'b0;
        end else begin
          s_cnt[k] = s_cnt[k] - 1;
        end
      end else if (stray) begin
        s_dok[k] = 1'b1;
      end else if (t_mreq[k] && $urandom_range(0, 2) != 0) begin
        s_aok[k]  = 1'b1;
        s_busy[k] = 1'b1;
        s_cnt[k]  = $urandom_range(0, 3);
        s_rd[k]   = t_mwr[k] ? $urandom : mem_fn(t_maddr[k]);
      end
    end
  endtask

  // ---------------- monitor / reference model ----------------
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned rd_idx [4];
  bit          md_busy [2];
  int          md_bside[2];
  bit          md_bwr  [2];
  logic [31:0] md_brd  [2];
  bit          md_lock [2];
  int          md_lside[2];
  int          md_last [2];
  bit          md_perr [2];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s env%0d @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      md_busy[k] = 1'b0; md_lock[k] = 1'b0; md_last[k] = 0; md_perr[k] = 1'b0;
      md_bside[k] = 0; md_lside[k] = 0; md_bwr[k] = 1'b0; md_brd[k] = '0;
    end
    for (int q = 0; q < 4; q++) rd_idx[q] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          chk("rst_m_req", k, 32'(t_mreq[k]), 0);
          chk("rst_m_addr", k, t_maddr[k], 0);
          chk("rst_m_wdata", k, t_mwdata[k], 0);
          chk("rst_m_wr_size", k, 32'({t_mwr[k], t_msize[k]}), 0);
          chk("rst_handshakes", k, 32'({t_aok[k][0], t_aok[k][1], t_dok[k][0], t_dok[k][1]}), 0);
          chk("rst_proto_err", k, 32'(t_perr[k]), 0);
          md_busy[k] = 1'b0; md_lock[k] = 1'b0; md_last[k] = 0; md_perr[k] = 1'b0;
          for (int s = 0; s < 2; s++) rd_idx[k*2+s] = exp_q[k*2+s].size();
        end else begin
          bit   exp_req;
          int   own;
          txn_t h;
          exp_req = 1'b0;
          own     = 0;
          h       = '0;
          chk("proto_err", k, 32'(t_perr[k]), 32'(md_perr[k]));
          if (md_busy[k]) begin
            exp_req = 1'b0;
          end else if (md_lock[k]) begin
            own     = md_lside[k];
            exp_req = t_req[k][own];
          end else if (t_req[k][0] || t_req[k][1]) begin
            exp_req = 1'b1;
            if (t_req[k][0] && t_req[k][1])
              own = (k == 0) ? 1 : ((md_last[k] == 0) ? 1 : 0);
            else
              own = t_req[k][1] ? 1 : 0;
          end
          chk("m_req", k, 32'(t_mreq[k]), 32'(exp_req));
          if (exp_req) begin
            if (rd_idx[k*2+own] < exp_q[k*2+own].size()) begin
              h = exp_q[k*2+own][rd_idx[k*2+own]];
              chk("m_addr", k, t_maddr[k], h.addr);
              chk("m_wdata", k, t_mwdata[k], h.wdata);
              chk("m_wr_size", k, 32'({t_mwr[k], t_msize[k]}), 32'({h.wr, h.size}));
            end else begin
              chk("scoreboard_empty", k, 1, 0);
            end
          end
          chk("i_addr_ok", k, 32'(t_aok[k][0]), 32'(exp_req && s_aok[k] && own == 0));
          chk("d_addr_ok", k, 32'(t_aok[k][1]), 32'(exp_req && s_aok[k] && own == 1));
          chk("i_data_ok", k, 32'(t_dok[k][0]), 32'(s_dok[k] && md_busy[k] && md_bside[k] == 0));
          chk("d_data_ok", k, 32'(t_dok[k][1]), 32'(s_dok[k] && md_busy[k] && md_bside[k] == 1));
          if (s_dok[k] && md_busy[k] && !md_bwr[k])
            chk("rdata", k, t_rdata[k][md_bside[k]], md_brd[k]);
          if ((s_dok[k] && !md_busy[k]) || (s_aok[k] && !exp_req)) md_perr[k] = 1'b1;
          if (md_busy[k]) begin
            if (s_dok[k]) md_busy[k] = 1'b0;
          end else if (exp_req) begin
            if (s_aok[k]) begin
              md_busy[k]  = 1'b1;
              md_bside[k] = own;
              md_bwr[k]   = h.wr;
              md_brd[k]   = mem_fn(h.addr);
              md_last[k]  = own;
              md_lock[k]  = 1'b0;
              rd_idx[k*2+own]++;
            end else begin
              md_lock[k]  = 1'b1;
              md_lside[k] = own;
            end
          end
        end
      end
    end
  end

  // ---------------- sequence ----------------
  task automatic drain();
    issue_en = 1'b0;
    for (int n = 0; n < 300 && !all_idle(); n++) cycle();
    if (!all_idle()) begin
      $display("FAIL drain_timeout: got busy expected idle");
      $fatal(1, "drain timeout");
    end
  endtask

  initial begin
    rst_next = 1'b1;
    issue_en = 1'b0;
    stray    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_aok[k] = 1'b0; s_dok[k] = 1'b0; s_rdata[k] = '0;
      s_busy[k] = 1'b0; s_cnt[k] = 0; s_rd[k] = '0;
      for (int s = 0; s < 2; s++) begin
        t_req[k][s] = 1'b0; t_wr[k][s] = 1'b0; t_size[k][s] = '0;
        t_addr[k][s] = '0; t_wdata[k][s] = '0; waiting[k][s] = 1'b0;
      end
    end

    repeat (3) cycle();
    rst_next = 1'b0;
    issue_en = 1'b1;
    repeat (3000) cycle();
    drain();

    // stray data return with nothing outstanding
    stray = 1'b1;
    cycle();
    stray = 1'b0;
    repeat (3) cycle();

    // reset while env0 is waiting for data
    issue_en = 1'b1;
    for (int n = 0; n < 100 && !s_busy[0]; n++) cycle();
    if (!s_busy[0]) begin
      $display("FAIL busy_timeout: got idle expected busy");
      $fatal(1, "busy timeout");
    end
    rst_next = 1'b1;
    cycle();
    rst_next = 1'b0;
    repeat (1500) cycle();
    drain();
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
